// File: rtl/bilinear_pkg.sv
// Shared types for the bilinear fetch path: Q8.8 fixed point, fetch FSM states
// and the captured neighbour quad.
package bilinear_pkg;
  localparam int          FRAC_BITS = 8;
  localparam logic [15:0] ONE_FX    = 16'h0100;

  typedef logic [15:0] fx_t;

  typedef enum logic [3:0] {
    ST_IDLE, ST_SETUP, ST_RD0, ST_RD1, ST_RD2, ST_RD3,
    ST_CAP, ST_PRESENT, ST_ADV, ST_FIN
  } fetch_state_t;

  typedef struct packed {
    logic [7:0] p00;
    logic [7:0] p10;
    logic [7:0] p01;
    logic [7:0] p11;
  } quad_t;
endpackage

// File: rtl/bilinear_fetch_unit_if.sv
// Source-memory read port plus the neighbour-set stream toward interpolation.
interface bilinear_fetch_unit_if #(
  parameter int DIM_W  = 10,
  parameter int ADDR_W = 20
) ();
  import bilinear_pkg::*;

  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;
  logic [7:0]        p00, p10, p01, p11;
  fx_t               a, b;
  logic              out_valid;
  logic              out_ready;
  logic [DIM_W-1:0]  dst_x, dst_y;

  modport master (
    output mem_rd, mem_addr, p00, p10, p01, p11, a, b, out_valid, dst_x, dst_y,
    input  mem_rdata, out_ready
  );

  modport slave (
    input  mem_rd, mem_addr, p00, p10, p01, p11, a, b, out_valid, dst_x, dst_y,
    output mem_rdata, out_ready
  );
endinterface

// File: rtl/bilinear_coord_step.sv
// Splits one Q(DIM_W).8 accumulator into neighbour indices and a fraction,
// clamping both indices to the last source row/column.
module bilinear_coord_step
  import bilinear_pkg::*;
#(
  parameter int DIM_W = 10
) (
  input  logic [DIM_W+FRAC_BITS-1:0] acc,
  input  logic [DIM_W-1:0]           src_dim,
  output logic [DIM_W-1:0]           i0,
  output logic [DIM_W-1:0]           i1,
  output logic [FRAC_BITS-1:0]       frac
);
  logic [DIM_W-1:0] ipart, last;

  always_comb begin
    ipart = acc[DIM_W+FRAC_BITS-1:FRAC_BITS];
    last  = src_dim - 1'b1;
    frac  = acc[FRAC_BITS-1:0];
    // At or past the edge both taps collapse; the fraction is left as-is.
    if (ipart >= last) begin
      i0 = last;
      i1 = last;
    end else begin
      i0 = ipart;
      i1 = ipart + 1'b1;
    end
  end
endmodule

// File: rtl/bilinear_fetch_unit.sv
// Raster-scans the destination, fetches the four source neighbours per pixel
// and hands them to the interpolator over a valid/ready handshake.
module bilinear_fetch_unit
  import bilinear_pkg::*;
#(
  parameter int DIM_W  = 10,
  parameter int ADDR_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DIM_W-1:0]  src_w,
  input  logic [DIM_W-1:0]  src_h,
  input  logic [DIM_W-1:0]  dst_w,
  input  logic [DIM_W-1:0]  dst_h,
  input  fx_t               scale_x,
  input  fx_t               scale_y,
  output logic              busy,
  output logic              done,
  bilinear_fetch_unit_if.master bus
);
  localparam int ACC_W = DIM_W + FRAC_BITS;

  fetch_state_t      state, nxt;
  logic [DIM_W-1:0]  sw, sh, dw, dh, dx, dy;
  fx_t               sx, sy;
  logic [ACC_W-1:0]  fx, fy;
  logic [ADDR_W-1:0] addr_q, rd_addr, row0, row1;
  quad_t             pix;
  logic [DIM_W-1:0]  x0, x1, y0, y1;
  logic [7:0]        fa, fb;
  logic              last_px;

  bilinear_coord_step #(.DIM_W(DIM_W)) u_step_x (.acc(fx), .src_dim(sw), .i0(x0), .i1(x1), .frac(fa));
  bilinear_coord_step #(.DIM_W(DIM_W)) u_step_y (.acc(fy), .src_dim(sh), .i0(y0), .i1(y1), .frac(fb));

  assign last_px = (dx == dw - 1'b1) && (dy == dh - 1'b1);
  assign row0    = ADDR_W'(y0) * ADDR_W'(sw);
  assign row1    = ADDR_W'(y1) * ADDR_W'(sw);

  // Address is live only during the read states; otherwise the last one is held.
  always_comb begin
    unique case (state)
      ST_RD0:  rd_addr = row0 + ADDR_W'(x0);
      ST_RD1:  rd_addr = row0 + ADDR_W'(x1);
      ST_RD2:  rd_addr = row1 + ADDR_W'(x0);
      ST_RD3:  rd_addr = row1 + ADDR_W'(x1);
      default: rd_addr = addr_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= ST_IDLE;
    else     state <= nxt;

  always_comb begin
    nxt           = state;
    bus.mem_rd    = 1'b0;
    bus.out_valid = 1'b0;
    busy          = 1'b1;
    done          = 1'b0;
    unique case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) nxt = ST_SETUP;
      end
      ST_SETUP:   nxt = (dw == '0 || dh == '0) ? ST_FIN : ST_RD0;
      ST_RD0:     begin bus.mem_rd = 1'b1; nxt = ST_RD1; end
      ST_RD1:     begin bus.mem_rd = 1'b1; nxt = ST_RD2; end
      ST_RD2:     begin bus.mem_rd = 1'b1; nxt = ST_RD3; end
      ST_RD3:     begin bus.mem_rd = 1'b1; nxt = ST_CAP; end
      ST_CAP:     nxt = ST_PRESENT;
      ST_PRESENT: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) nxt = ST_ADV;
      end
      ST_ADV:     nxt = last_px ? ST_FIN : ST_RD0;
      ST_FIN:     begin done = 1'b1; nxt = ST_IDLE; end
      default:    nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw <= '0; sh <= '0; dw <= '0; dh <= '0; sx <= '0; sy <= '0;
      dx <= '0; dy <= '0; fx <= '0; fy <= '0;
      addr_q <= '0; pix <= '0;
    end else begin
      addr_q <= rd_addr;
      unique case (state)
        ST_IDLE: if (start) begin
          sw <= src_w; sh <= src_h; dw <= dst_w; dh <= dst_h;
          sx <= scale_x; sy <= scale_y;
          dx <= '0; dy <= '0; fx <= '0; fy <= '0;
        end
        // Read data lags the strobe by one cycle, hence the one-state offset.
        ST_RD1: pix.p00 <= bus.mem_rdata;
        ST_RD2: pix.p10 <= bus.mem_rdata;
        ST_RD3: pix.p01 <= bus.mem_rdata;
        ST_CAP: pix.p11 <= bus.mem_rdata;
        ST_ADV: if (!last_px) begin
          if (dx < dw - 1'b1) begin
            dx <= dx + 1'b1;
            fx <= fx + ACC_W'(sx);
          end else begin
            dx <= '0;
            fx <= '0;
            dy <= dy + 1'b1;
            fy <= fy + ACC_W'(sy);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_addr = rd_addr;
  assign bus.p00      = pix.p00;
  assign bus.p10      = pix.p10;
  assign bus.p01      = pix.p01;
  assign bus.p11      = pix.p11;
  assign bus.a        = fx_t'({8'h00, fa});
  assign bus.b        = fx_t'({8'h00, fb});
  assign bus.dst_x    = dx;
  assign bus.dst_y    = dy;
endmodule
